// File: rtl/fb_pixel_writer.sv
// Frame-buffer loader: assembles R,G,B bytes from a byte stream into 6-bit pixels
// and writes them linearly into three RAM planes, one pixel per address.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; no bytes accepted
// S_GET_R | in_ready high, waiting for the red byte
// S_GET_G | in_ready high, waiting for the green byte
// S_GET_B | in_ready high, waiting for the blue byte
// S_WRITE | wr_en high for one cycle; advance address or finish frame
module fb_pixel_writer #(
    parameter int NPIX = 10000,
    parameter int AW   = 16,
    parameter int DW   = 6
) (
    input  logic          clkq,
    input  logic          rstn,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_dR,
    output logic [DW-1:0] wr_dG,
    output logic [DW-1:0] wr_dB,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_R,
        S_GET_G,
        S_GET_B,
        S_WRITE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] hold_r_q, hold_r_d;
    logic [DW-1:0] hold_g_q, hold_g_d;
    logic          in_ready_q, in_ready_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_dr_q, wr_dr_d;
    logic [DW-1:0] wr_dg_q, wr_dg_d;
    logic [DW-1:0] wr_db_q, wr_db_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          accept;
    logic [DW-1:0] byte_px;
    logic          last_pix;

    // Low bits of each byte are dropped by truncation to the channel width.
    logic          unused_in_bits;
    assign unused_in_bits = ^in_data;

    assign accept   = in_valid && in_ready_q;
    assign byte_px  = in_data[7 -: DW];
    assign last_pix = (cnt_q == AW'(NPIX - 1));

    always_ff @(posedge clkq or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hold_r_q   <= '0;
            hold_g_q   <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_dr_q    <= '0;
            wr_dg_q    <= '0;
            wr_db_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_r_q   <= hold_r_d;
            hold_g_q   <= hold_g_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_dr_q    <= wr_dr_d;
            wr_dg_q    <= wr_dg_d;
            wr_db_q    <= wr_db_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_r_d  = hold_r_q;
        hold_g_d  = hold_g_q;
        wr_addr_d = wr_addr_q;
        wr_dr_d   = wr_dr_q;
        wr_dg_d   = wr_dg_q;
        wr_db_d   = wr_db_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_GET_R;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_GET_R: begin
                if (accept) begin
                    hold_r_d = byte_px;
                    state_d  = S_GET_G;
                end
            end
            S_GET_G: begin
                if (accept) begin
                    hold_g_d = byte_px;
                    state_d  = S_GET_B;
                end
            end
            S_GET_B: begin
                // Write-side registers load here so they are valid in the WRITE cycle.
                if (accept) begin
                    wr_addr_d = cnt_q;
                    wr_dr_d   = hold_r_q;
                    wr_dg_d   = hold_g_q;
                    wr_db_d   = byte_px;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_pix) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_GET_R;
                    cnt_d   = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (busy_q) begin
            if (start) begin
                err_d = 1'b1;
            end
            // Abort beats everything else; a pending write-side load is discarded.
            if (abort) begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                done_d    = 1'b0;
                wr_addr_d = wr_addr_q;
                wr_dr_d   = wr_dr_q;
                wr_dg_d   = wr_dg_q;
                wr_db_d   = wr_db_q;
            end
        end

        in_ready_d = (state_d == S_GET_R) || (state_d == S_GET_G) || (state_d == S_GET_B);
        wr_en_d    = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_dR    = wr_dr_q;
    assign wr_dG    = wr_dg_q;
    assign wr_dB    = wr_db_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench: small 4-pixel instance for protocol cases, default-size instance
// for a full 10000-pixel frame.
module tb_fb_pixel_writer;

    logic clkq = 1'b0;
    always #5 clkq = ~clkq;

    logic       rstn, start, abort, in_valid;
    logic [7:0] in_data;
    logic       in_ready, wr_en, busy, done, err;
    logic [1:0] wr_addr;
    logic [5:0] wr_dR, wr_dG, wr_dB;

    logic        b_rstn, b_start, b_abort, b_in_valid;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_wr_en, b_busy, b_done, b_err;
    logic [15:0] b_wr_addr;
    logic [5:0]  b_wr_dR, b_wr_dG, b_wr_dB;

    fb_pixel_writer #(.NPIX(4), .AW(2), .DW(6)) u_small (
        .clkq(clkq), .rstn(rstn), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_dR(wr_dR), .wr_dG(wr_dG), .wr_dB(wr_dB),
        .busy(busy), .done(done), .err(err)
    );

    fb_pixel_writer u_big (
        .clkq(clkq), .rstn(b_rstn), .start(b_start), .abort(b_abort),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_dR(b_wr_dR), .wr_dG(b_wr_dG), .wr_dB(b_wr_dB),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] frame [12] = '{8'hFC, 8'h80, 8'h04, 8'h00, 8'hFF, 8'h40,
                               8'h10, 8'h20, 8'h30, 8'hFF, 8'hFF, 8'hFF};
    logic [5:0] exp_r [4] = '{6'h3F, 6'h00, 6'h04, 6'h3F};
    logic [5:0] exp_g [4] = '{6'h20, 6'h3F, 6'h08, 6'h3F};
    logic [5:0] exp_b [4] = '{6'h01, 6'h10, 6'h0C, 6'h3F};

    int cyc = 0;
    always @(posedge clkq) cyc <= cyc + 1;

    int log_addr[$], log_r[$], log_g[$], log_b[$], log_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;

    always @(negedge clkq) begin
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_r.push_back(int'(wr_dR));
            log_g.push_back(int'(wr_dG));
            log_b.push_back(int'(wr_dB));
            log_cyc.push_back(cyc);
            check_val("ready_in_write", in_ready, 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check_val("busy_at_done", busy, 0);
        end
    end

    function automatic logic [7:0] bbyte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    int b_wcnt = 0, b_bad = 0, b_maxaddr = 0, b_done_cnt = 0;

    always @(negedge clkq) begin
        logic [7:0] tr, tg, tb;
        if (b_wr_en) begin
            tr = bbyte(3 * b_wcnt);
            tg = bbyte(3 * b_wcnt + 1);
            tb = bbyte(3 * b_wcnt + 2);
            if (b_wr_addr != 16'(b_wcnt) || b_wr_dR != tr[7:2] ||
                b_wr_dG != tg[7:2] || b_wr_dB != tb[7:2])
                b_bad++;
            if (int'(b_wr_addr) > b_maxaddr) b_maxaddr = int'(b_wr_addr);
            b_wcnt++;
        end
        if (b_done) b_done_cnt++;
    end

    task automatic tick();
        @(posedge clkq);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            @(negedge clkq);
            acc = in_ready;
            tick();
            n++;
        end
        if (!acc) check_val("accept_timeout", 0, 1);
    endtask

    task automatic send_range(input int first, input int last, input bit rnd);
        for (int i = first; i <= last; i++)
            send_byte(frame[i], rnd ? int'($urandom_range(0, 2)) : 0);
        in_valid = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_r.delete();
        log_g.delete();
        log_b.delete();
        log_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic check_frame(input string tag, input int nexp);
        check_val({tag, "_nwr"}, log_addr.size(), nexp);
        for (int k = 0; k < nexp && k < log_addr.size(); k++) begin
            check_val({tag, "_addr"}, log_addr[k], k);
            check_val({tag, "_r"}, log_r[k], exp_r[k]);
            check_val({tag, "_g"}, log_g[k], exp_g[k]);
            check_val({tag, "_b"}, log_b[k], exp_b[k]);
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_rstn = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
        repeat (3) tick();
        check_val("rst_ctrl", {in_ready, wr_en, busy, done, err}, 0);
        check_val("rst_data", {wr_addr, wr_dR, wr_dG, wr_dB}, 0);
        rstn = 1'b1;
        b_rstn = 1'b1;
        tick();

        // back-to-back bytes
        clear_log();
        pulse_start();
        check_val("f1_busy", busy, 1);
        check_val("f1_ready", in_ready, 1);
        send_range(0, 11, 1'b0);
        repeat (4) tick();
        check_frame("f1", 4);
        for (int k = 1; k < 4; k++)
            check_val("f1_spacing", log_cyc[k] - log_cyc[k-1], 4);
        check_val("f1_done_cnt", done_cnt, 1);
        check_val("f1_done_cyc", done_cyc - log_cyc[3], 1);
        check_val("f1_idle", {busy, done, in_ready}, 0);

        // gappy valid
        clear_log();
        pulse_start();
        send_range(0, 11, 1'b1);
        repeat (4) tick();
        check_frame("f2", 4);
        check_val("f2_done_cnt", done_cnt, 1);

        // start while busy sets err, frame continues
        clear_log();
        pulse_start();
        send_range(0, 3, 1'b0);
        pulse_start();
        check_val("f3_err_set", err, 1);
        send_range(4, 11, 1'b0);
        repeat (4) tick();
        check_frame("f3", 4);
        check_val("f3_done_cnt", done_cnt, 1);
        check_val("f3_err_sticky", err, 1);
        clear_log();
        pulse_start();
        check_val("f3_err_clr", err, 0);

        // abort in GET_B of pixel 2
        send_range(0, 7, 1'b0);
        pulse_abort();
        check_val("ab_busy", busy, 0);
        check_val("ab_ready", in_ready, 0);
        in_data = 8'hAA;
        in_valid = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        check_val("ab_nwr", log_addr.size(), 2);
        check_val("ab_last_addr", log_addr[1], 1);
        check_val("ab_done_cnt", done_cnt, 0);
        clear_log();
        pulse_start();
        send_range(0, 11, 1'b0);
        repeat (4) tick();
        check_frame("f4", 4);
        check_val("f4_done_cnt", done_cnt, 1);

        // async reset in GET_B of pixel 1
        clear_log();
        pulse_start();
        send_range(0, 4, 1'b0);
        pulse_start();
        check_val("rs_err_pre", err, 1);
        #3;
        rstn = 1'b0;
        #1;
        check_val("rs_ctrl", {in_ready, wr_en, busy, done, err}, 0);
        check_val("rs_data", {wr_addr, wr_dR, wr_dG, wr_dB}, 0);
        #3;
        rstn = 1'b1;
        in_data = 8'h55;
        in_valid = 1'b1;
        repeat (10) tick();
        in_valid = 1'b0;
        check_val("rs_nwr", log_addr.size(), 1);
        check_val("rs_idle", {in_ready, busy}, 0);
        clear_log();
        pulse_start();
        send_range(0, 11, 1'b0);
        repeat (4) tick();
        check_frame("f5", 4);

        // full-size frame
        begin
            bit acc;
            bit stuck;
            int n;
            stuck = 1'b0;
            b_start = 1'b1;
            tick();
            b_start = 1'b0;
            for (int i = 0; i < 30000 && !stuck; i++) begin
                b_in_data  = bbyte(i);
                b_in_valid = 1'b1;
                acc = 1'b0;
                n = 0;
                while (!acc && n < 40) begin
                    @(negedge clkq);
                    acc = b_in_ready;
                    tick();
                    n++;
                end
                if (!acc) begin
                    check_val("big_accept_timeout", 0, 1);
                    stuck = 1'b1;
                end
            end
            b_in_valid = 1'b0;
            repeat (6) tick();
        end
        check_val("big_nwr", b_wcnt, 10000);
        check_val("big_bad", b_bad, 0);
        check_val("big_max_addr", b_maxaddr, 9999);
        check_val("big_done_cnt", b_done_cnt, 1);
        check_val("big_idle", {b_busy, b_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
